// File: rtl/fetch_pc_pkg.sv
// Shared processor definitions for the fetch stage: FSM state encoding and the default reset PC.
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    localparam logic [7:0] RESET_PC_DEF = 8'h00;

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_pc_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/adder_internal.sv
// Sequential-PC adder: zero-extends the 3-bit instruction length and drops the carry.
module adder_internal #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [2:0]   b,
    output logic [W-1:0] y
);
    assign y = a + W'(b);
endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage PC and instruction register with IDLE/FETCH/HOLD control.
// Define FETCH_PERF_CNT_EN to add the 16-bit fetch_cnt transfer counter.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [2:0]         inc,
    fetch_pc_if.master         imem,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, pc_seq;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req;
    logic               xfer_ok;

    adder_internal #(
        .W (PC_W)
    ) u_pc_adder (
        .a (pc_q),
        .b (inc),
        .y (pc_seq)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req     = 1'b0;
        xfer_ok = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                req = ~stall;
                if (stall) begin
                    state_d = StHold;
                end else if (imem.imem_ready) begin
                    xfer_ok = 1'b1;
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    pc_d    = pc_seq;
                end else begin
                    valid_d = 1'b0;
                end
            end
            StHold: begin
                if (!stall) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase

        // A redirect overrides everything and discards any same-edge transfer.
        if (br_taken) begin
            state_d = state_q;
            pc_d    = br_target;
            instr_d = instr_q;
            valid_d = 1'b0;
            xfer_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer_ok) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = cnt_q;
`endif

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter PC_W, default 8, PC and address width; matches the 8-bit operand of the sequential-PC adder.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 Port stall  input  1  downstream hold request.
REQ-007 Port br_taken  input  1  redirect request, single-cycle pulse.
REQ-008 Port br_target  input  PC_W  redirect address.
REQ-009 Port inc  input  3  length of the current instruction, 0..7.
REQ-010 Port imem_req  output  1  instruction memory request valid.
REQ-011 Port imem_addr  output  PC_W  request address, always equal to pc.
REQ-012 Port imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-013 Port imem_rdata  input  INSTR_W  returned instruction, valid when imem_req & imem_ready.
REQ-014 Port pc  output  PC_W  current fetch PC.
REQ-015 Port instr  output  INSTR_W  registered instruction.
REQ-016 Port instr_valid  output  1  instr holds a live instruction.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and HOLD; IDLE SHALL always move to FETCH on the next cycle.
REQ-018 In FETCH with stall=0, imem_req SHALL be 1; in IDLE, in HOLD and whenever stall=1, imem_req SHALL be 0.
REQ-019 A transfer SHALL occur when imem_req=1 and imem_ready=1 on the same edge.
- instr <= imem_rdata
- instr_valid <= 1
- pc <= (pc + inc) mod 2^PC_W
- result visible one cycle after the transfer (latency 1).
REQ-020 In FETCH, imem_req=1 and imem_ready=0 SHALL hold pc and instr, and SHALL clear instr_valid.
REQ-021 FETCH with stall=1 SHALL move to HOLD; HOLD SHALL keep pc, instr and instr_valid unchanged and return to FETCH when stall=0.
REQ-022 The sequential-PC sum SHALL zero-extend inc to PC_W and drop the carry.
- FE+3 = 01
- inc=0 leaves pc unchanged.
REQ-023 br_taken=1 SHALL take priority over every other event, in any state other than reset.
- pc <= br_target
- instr_valid <= 0
- any transfer completing on the same edge is discarded
- state is unchanged, except HOLD, which keeps its state.
REQ-024 br_taken together with rst_n=0 SHALL follow reset.

Reset
REQ-025 rst_n=0 at a clock edge SHALL set, regardless of state or an in-flight transfer:
- pc = RESET_PC
- instr = 0
- instr_valid = 0
- imem_req = 0
- state = IDLE.
REQ-026 The first request SHALL be issued in the second cycle after rst_n rises (IDLE, then FETCH).

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined, the block SHALL add:
- output fetch_cnt, 16 bits
- fetch_cnt increments on every non-discarded transfer
- fetch_cnt wraps FFFF->0000
- fetch_cnt resets to 0 with rst_n.
REQ-028 Without FETCH_PERF_CNT_EN, fetch_cnt and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-029 The FSM state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2) and the RESET_PC default SHALL live in the shared processor package.
REQ-030 The sequential PC SHALL be computed by one instance of adder_internal:
- a = pc
- b = inc
- y feeds the pc next-state logic.

Verification
REQ-031 Reset release, imem_ready=1, inc=2 -> imem_addr 00, 02, 04 on successive FETCH cycles; instr_valid rises 1 cycle after the first transfer.
REQ-032 pc=FE, inc=3, transfer -> pc=01 next cycle.
REQ-033 Transfer and br_taken=1 with br_target=40 on the same edge -> pc=40, instr_valid=0, returned data discarded.
REQ-034 stall=1 for 3 cycles in FETCH -> imem_req=0 and pc, instr, instr_valid frozen; fetch resumes at the same pc.
REQ-035 imem_ready=0 for 2 cycles -> imem_req=1 held, imem_addr stable, instr_valid=0.
REQ-036 rst_n=0 mid-transfer with RESET_PC=10 -> pc=10, instr_valid=0, imem_req=0; with FETCH_PERF_CNT_EN defined, fetch_cnt=0.
